fetch_sequencer: RTL and testbench

//   Program-counter sequencer for the word-addressed instruction memory. Drives AddressBus and

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: drives the instruction memory address and
// hands downstream a registered {instruction, pc} pair with a valid flag.
module fetch_sequencer #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] AddressBus,
    input  logic [31:0] InstructionIn,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_fpc;
    logic        r_halted;
    logic        r_fault;

    state_t      w_state;
    logic [31:0] w_pc;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_fpc;
    logic        w_stop;
    logic        w_is_j;
    logic [31:0] w_imm;
    logic        w_oob;

    assign w_stop = InstructionIn[0];
    assign w_is_j = (InstructionIn[2:1] == 2'b10);
    assign w_imm  = {{8{InstructionIn[26]}}, InstructionIn[26:3]};
    assign w_oob  = (r_pc >= MEM_DEPTH);

    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_valid = r_valid;
        w_instr = r_instr;
        w_fpc   = r_fpc;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc    = RESET_PC;
                    w_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (start) begin
                    w_pc    = RESET_PC;
                    w_valid = 1'b0;
                end else if (redirect_valid) begin
                    w_pc    = redirect_target;
                    w_valid = 1'b0;
                end else if (w_oob) begin
                    w_valid = 1'b0;
                    w_state = S_FAULT;
                end else if (!stall) begin
                    w_instr = InstructionIn;
                    w_fpc   = r_pc;
                    w_valid = 1'b1;
                    // Stop word is delivered but PC parks on it
                    if (w_stop)
                        w_state = S_HALT;
                    else if (w_is_j)
                        w_pc = r_pc + w_imm;
                    else
                        w_pc = r_pc + 32'd1;
                end
            end
            S_HALT, S_FAULT: begin
                if (start) begin
                    w_pc    = RESET_PC;
                    w_valid = 1'b0;
                    w_state = S_FETCH;
                end else if (!stall) begin
                    w_valid = 1'b0;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= 32'd0;
            r_fpc    <= 32'd0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_valid  <= w_valid;
            r_instr  <= w_instr;
            r_fpc    <= w_fpc;
            r_halted <= (w_state == S_HALT);
            r_fault  <= (w_state == S_FAULT);
        end
    end

    assign AddressBus  = r_pc;
    assign fetch_valid = r_valid;
    assign fetch_instr = r_instr;
    assign fetch_pc    = r_fpc;
    assign halted      = r_halted;
    assign fault       = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected
// {pc, instr} beats, a negedge monitor pops them as downstream accepts.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] AddressBus;
    logic [31:0] InstructionIn;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic        halted;
    logic        fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [0:255];
    int          checks   = 0;
    int          failures = 0;

    fetch_sequencer #(.MEM_DEPTH(256), .RESET_PC(32'd0)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .AddressBus      (AddressBus),
        .InstructionIn   (InstructionIn),
        .fetch_valid     (fetch_valid),
        .fetch_instr     (fetch_instr),
        .fetch_pc        (fetch_pc),
        .halted          (halted),
        .fault           (fault)
    );

    always #5 clock = ~clock;

    always_comb begin
        InstructionIn = 32'd0;
        if (AddressBus < 32'd256)
            InstructionIn = mem[AddressBus[7:0]];
    end

    function automatic logic [31:0] mk(input logic [4:0] fn,
                                       input logic [1:0] ty,
                                       input logic st,
                                       input logic [23:0] imm);
        return {fn, imm, ty, st};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic push(input int pc);
        exp_t e;
        e.pc    = 32'(pc);
        e.instr = mem[pc];
        q.push_back(e);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n;
        n = 0;
        while (!halted && n < 60) begin
            tick();
            n++;
        end
        chk(name, {31'd0, halted}, 32'd1);
    endtask

    // Monitor: a beat is consumed when valid is presented with no stall
    always @(negedge clock) begin
        if (reset && fetch_valid && !stall) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL beat: unexpected pc=%0h instr=%0h",
                         fetch_pc, fetch_instr);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (fetch_pc !== e.pc || fetch_instr !== e.instr) begin
                    failures++;
                    $display("FAIL beat: got pc=%0h instr=%0h expected pc=%0h instr=%0h",
                             fetch_pc, fetch_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        for (int i = 0; i < 256; i++)
            mem[i] = mk(5'(i), 2'b01, 1'b0, 24'(i));
        mem[0]   = mk(5'd1, 2'b01, 1'b0, 24'h000023);
        mem[1]   = mk(5'd1, 2'b01, 1'b0, 24'h000055);
        mem[2]   = mk(5'd2, 2'b00, 1'b1, 24'h000112);
        mem[10]  = mk(5'd9, 2'b10, 1'b0, 24'hFFFFFC);
        mem[41]  = mk(5'd3, 2'b11, 1'b1, 24'h000000);

        #12;
        chk("rst_addr", AddressBus, 32'd0);
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_instr", fetch_instr, 32'd0);
        chk("rst_pc", fetch_pc, 32'd0);
        chk("rst_flags", {30'd0, halted, fault}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 1: three-word program, stop on word 2
        push(0); push(1); push(2);
        pulse_start();
        wait_halt("t1_halt");
        tick();
        chk("t1_valid_drop", {31'd0, fetch_valid}, 32'd0);
        chk("t1_addr", AddressBus, 32'd2);
        redirect_valid  = 1'b1;
        redirect_target = 32'd40;
        tick();
        redirect_valid  = 1'b0;
        chk("halt_ignores_redirect", AddressBus, 32'd2);

        // 2: stall holds at fetch_pc=1
        push(0); push(1); push(2);
        pulse_start();
        tick();
        tick();
        chk("t2_pc1", fetch_pc, 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_addr", AddressBus, 32'd2);
            chk("t2_hold_pc", fetch_pc, 32'd1);
        end
        stall = 1'b0;
        tick();
        chk("t2_after_stall", fetch_pc, 32'd2);
        wait_halt("t2_halt");

        // 3: redirect wins over stall
        mem[2] = mk(5'd2, 2'b00, 1'b0, 24'h000112);
        push(0); push(1); push(2); push(3); push(40); push(41);
        pulse_start();
        repeat (5) tick();
        chk("t3_pc5", AddressBus, 32'd5);
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'd40;
        tick();
        redirect_valid  = 1'b0;
        chk("t3_redir_addr", AddressBus, 32'd40);
        chk("t3_squash", {31'd0, fetch_valid}, 32'd0);
        stall = 1'b0;
        tick();
        chk("t3_capture", fetch_pc, 32'd40);
        wait_halt("t3_halt");

        // 4: backward J-type jump 10 -> 6
        mem[7] = mk(5'd4, 2'b01, 1'b1, 24'h000007);
        push(8); push(9); push(10); push(6); push(7);
        pulse_start();
        redirect_valid  = 1'b1;
        redirect_target = 32'd8;
        tick();
        redirect_valid  = 1'b0;
        wait_halt("t4_halt");
        chk("t4_last_pc", fetch_pc, 32'd7);

        // 5: last legal word then fault, start recovers
        push(255);
        pulse_start();
        redirect_valid  = 1'b1;
        redirect_target = 32'd255;
        tick();
        redirect_valid  = 1'b0;
        tick();
        chk("t5_addr256", AddressBus, 32'd256);
        tick();
        chk("t5_fault", {31'd0, fault}, 32'd1);
        chk("t5_valid", {31'd0, fetch_valid}, 32'd0);
        for (int i = 0; i < 8; i++) push(i);
        pulse_start();
        chk("t5_restart_addr", AddressBus, 32'd0);
        chk("t5_fault_clr", {31'd0, fault}, 32'd0);
        wait_halt("t5_halt");

        // 6: async reset mid-fetch under stall
        for (int i = 0; i < 6; i++) push(i);
        pulse_start();
        repeat (7) tick();
        chk("t6_pc7", AddressBus, 32'd7);
        stall = 1'b1;
        tick();
        chk("t6_hold_pc", fetch_pc, 32'd6);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_addr", AddressBus, 32'd0);
        chk("t6_rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("t6_rst_instr", fetch_instr, 32'd0);
        chk("t6_rst_pc", fetch_pc, 32'd0);
        chk("t6_rst_flags", {30'd0, halted, fault}, 32'd0);
        tick();
        reset = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_idle_valid", {31'd0, fetch_valid}, 32'd0);
            chk("t6_idle_addr", AddressBus, 32'd0);
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'd40;
        tick();
        redirect_valid  = 1'b0;
        chk("idle_ignores_redirect", AddressBus, 32'd0);

        tick();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
